// File: rtl/cp0_timer_unit_if.sv
// cp0_timer_unit_if
// MTC0/MFC0 register access bus between the pipeline and the CP0 block.
//   we, waddr, wdata : MTC0 write port (driven by the core)
//   re, raddr        : MFC0 read request (driven by the core)
//   rdata            : MFC0 read data, combinational (driven by CP0)
interface cp0_timer_unit_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  raddr;
  logic [31:0] rdata;

  modport master (output we, waddr, wdata, re, raddr, input rdata);
  modport slave  (input we, waddr, wdata, re, raddr, output rdata);
endinterface

// File: rtl/cp0_timer_unit.sv
// cp0_timer_unit
// CP0 coprocessor for MiniMIPS32: BadVAddr, Count, Compare, Status, Cause, EPC,
// exception entry / ERET return, interrupt request and Count/Compare timer.
// Ports:
//   cpu_clk_50M, cpu_rst : clock, synchronous active-high reset
//   cp0_bus (slave)      : MTC0 write / MFC0 read bus
//   int_i                : level-sensitive hardware interrupt lines
//   exc_valid, exccode_i, exc_pc_i, in_delay_i, exc_badvaddr_i : committed exception
//   eret_i               : committed ERET
//   flush, excaddr       : pipeline flush and redirect target
//   int_req, timer_int   : interrupt request to the core, timer interrupt flag
//   status_o, cause_o    : Status / Cause register views
module cp0_timer_unit #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC00380,
  parameter logic [31:0] RESET_PC   = 32'hBFC00000
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  cp0_timer_unit_if.slave       cp0_bus,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid,
  input  logic [4:0]            exccode_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  in_delay_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic                  flush,
  output logic [31:0]           excaddr,
  output logic                  int_req,
  output logic                  timer_int,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [31:0] PRESC_MAX     = 32'(COUNT_DIV - 1);

  logic [31:0] r_badvaddr, r_count, r_compare, r_epc, r_presc;
  logic [7:0]  r_im;
  logic        r_exl, r_ie;
  logic        r_bd, r_armed, r_timer_int;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;

  logic [5:0]  w_ip_hw;
  logic        w_wrap;
  logic        w_mtc0;

  // Writes lose to a simultaneous exception or ERET.
  assign w_mtc0 = cp0_bus.we & ~exc_valid & ~eret_i;
  assign w_wrap = (r_presc == PRESC_MAX);

  // Hardware IP bits follow int_i; IP7 additionally carries the timer.
  always_comb begin
    w_ip_hw = '0;
    for (int k = 0; k < NUM_HW_INT; k++) begin
      w_ip_hw[k] = int_i[k];
    end
    w_ip_hw[5] = w_ip_hw[5] | r_timer_int;
  end

  assign status_o  = {3'b000, 1'b1, 12'b0, r_im, 6'b0, r_exl, r_ie};
  assign cause_o   = {r_bd, r_timer_int, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};
  assign timer_int = r_timer_int;
  assign int_req   = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));
  assign flush     = ~cpu_rst & (exc_valid | eret_i);

  // Redirect target; an MTC0 to EPC in the ERET cycle is forwarded directly.
  always_comb begin
    excaddr = 32'h0;
    if (cpu_rst)
      excaddr = RESET_PC;
    else if (exc_valid)
      excaddr = EXC_ENTRY;
    else if (eret_i && cp0_bus.we && cp0_bus.waddr == ADDR_EPC)
      excaddr = cp0_bus.wdata;
    else if (eret_i)
      excaddr = r_epc;
  end

  always_comb begin
    cp0_bus.rdata = 32'h0;
    if (cp0_bus.re) begin
      case (cp0_bus.raddr)
        ADDR_BADVADDR: cp0_bus.rdata = r_badvaddr;
        ADDR_COUNT:    cp0_bus.rdata = r_count;
        ADDR_COMPARE:  cp0_bus.rdata = r_compare;
        ADDR_STATUS:   cp0_bus.rdata = status_o;
        ADDR_CAUSE:    cp0_bus.rdata = cause_o;
        ADDR_EPC:      cp0_bus.rdata = r_epc;
        default:       cp0_bus.rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_badvaddr  <= '0;
      r_count     <= '0;
      r_compare   <= '0;
      r_epc       <= '0;
      r_presc     <= '0;
      r_im        <= '0;
      r_exl       <= 1'b0;
      r_ie        <= 1'b0;
      r_bd        <= 1'b0;
      r_armed     <= 1'b0;
      r_timer_int <= 1'b0;
      r_ip_hw     <= '0;
      r_ip_sw     <= '0;
      r_exccode   <= '0;
    end else begin
      r_ip_hw <= w_ip_hw;

      // Count only advances when the prescaler wraps; a Count write restarts it.
      if (w_mtc0 && cp0_bus.waddr == ADDR_COUNT) begin
        r_count <= cp0_bus.wdata;
        r_presc <= '0;
      end else if (w_wrap) begin
        r_count <= r_count + 32'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 32'd1;
      end

      // A Compare write beats a match landing in the same cycle.
      if (w_mtc0 && cp0_bus.waddr == ADDR_COMPARE) begin
        r_compare   <= cp0_bus.wdata;
        r_armed     <= 1'b1;
        r_timer_int <= 1'b0;
      end else if (r_armed && w_wrap && r_count == r_compare) begin
        r_timer_int <= 1'b1;
      end

      // Nested exceptions (EXL already set) keep the original EPC/BD.
      if (exc_valid) begin
        if (!r_exl) begin
          r_epc <= in_delay_i ? exc_pc_i - 32'd4 : exc_pc_i;
          r_bd  <= in_delay_i;
        end
        r_exl     <= 1'b1;
        r_exccode <= exccode_i;
        if (exccode_i == 5'h04 || exccode_i == 5'h05)
          r_badvaddr <= exc_badvaddr_i;
      end else if (eret_i) begin
        r_exl <= 1'b0;
      end else if (w_mtc0) begin
        case (cp0_bus.waddr)
          ADDR_STATUS: begin
            r_im  <= cp0_bus.wdata[15:8];
            r_exl <= cp0_bus.wdata[1];
            r_ie  <= cp0_bus.wdata[0];
          end
          ADDR_CAUSE: r_ip_sw <= cp0_bus.wdata[9:8];
          ADDR_EPC:   r_epc   <= cp0_bus.wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_timer_unit.sv
// tb_cp0_timer_unit
// Directed bench for cp0_timer_unit with default parameters (COUNT_DIV=2).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_cp0_timer_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  intIn;
  logic        excValid;
  logic [4:0]  excCode;
  logic [31:0] excPc;
  logic        inDelay;
  logic [31:0] excBadVaddr;
  logic        eret;
  logic        flush;
  logic [31:0] excAddr;
  logic        intReq;
  logic        timerInt;
  logic [31:0] statusOut;
  logic [31:0] causeOut;

  int checkCount;
  int errorCount;

  cp0_timer_unit_if bus();

  cp0_timer_unit dut (
    .cpu_clk_50M    (clk),
    .cpu_rst        (rst),
    .cp0_bus        (bus.slave),
    .int_i          (intIn),
    .exc_valid      (excValid),
    .exccode_i      (excCode),
    .exc_pc_i       (excPc),
    .in_delay_i     (inDelay),
    .exc_badvaddr_i (excBadVaddr),
    .eret_i         (eret),
    .flush          (flush),
    .excaddr        (excAddr),
    .int_req        (intReq),
    .timer_int      (timerInt),
    .status_o       (statusOut),
    .cause_o        (causeOut)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One MTC0 write cycle
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    bus.we    = 1'b1;
    bus.waddr = addr;
    bus.wdata = data;
    tick();
    bus.we    = 1'b0;
  endtask

  // MFC0 read of one register (combinational, no clock needed)
  task automatic readCheck(input string tag, input logic [4:0] addr, input logic [31:0] expected);
    bus.re    = 1'b1;
    bus.raddr = addr;
    #1;
    checkOutput(tag, bus.rdata, expected);
    bus.re    = 1'b0;
  endtask

  task automatic clearExc();
    excValid    = 1'b0;
    eret        = 1'b0;
    bus.we      = 1'b0;
  endtask

  // Directed sequence; expected values are hand-derived for COUNT_DIV=2
  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst         = 1'b1;
    intIn       = '0;
    excValid    = 1'b1;
    excCode     = 5'h04;
    excPc       = 32'h80000000;
    inDelay     = 1'b0;
    excBadVaddr = 32'h0;
    eret        = 1'b0;
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.re      = 1'b0;
    bus.raddr   = '0;

    // Reset with a pending exception: no flush, redirect to reset vector
    repeat (3) tick();
    checkOutput("rstFlush", {31'b0, flush}, 32'h0);
    checkOutput("rstExcAddr", excAddr, 32'hBFC00000);
    excValid = 1'b0;
    rst      = 1'b0;

    readCheck("rstCount", 5'd9, 32'h0);
    readCheck("rstStatus", 5'd12, 32'h10000000);
    readCheck("rstCause", 5'd13, 32'h0);
    tick();
    readCheck("rstCompare", 5'd11, 32'h0);
    readCheck("rstEpc", 5'd14, 32'h0);
    readCheck("rstBadVaddr", 5'd8, 32'h0);
    tick();
    readCheck("unmappedAddr", 5'd3, 32'h0);
    bus.re = 1'b0;
    bus.raddr = 5'd12;
    #1;
    checkOutput("readDisabled", bus.rdata, 32'h0);
    checkOutput("rstIntReq", {31'b0, intReq}, 32'h0);
    checkOutput("idleExcAddr", excAddr, 32'h0);
    repeat (8) tick();
    readCheck("countAfter10", 5'd9, 32'd5);

    // Hardware interrupt gating through IM/IE/EXL
    intIn[0] = 1'b1;
    #1;
    checkOutput("intReqBeforeSample", {31'b0, intReq}, 32'h0);
    applyStimulus(5'd12, 32'h00000401);
    checkOutput("statusIm2Ie", statusOut, 32'h10000401);
    checkOutput("causeIp2", causeOut, 32'h00000400);
    checkOutput("intReqHw", {31'b0, intReq}, 32'h1);
    applyStimulus(5'd12, 32'h00000403);
    checkOutput("statusExl", statusOut, 32'h10000403);
    checkOutput("intReqExlMask", {31'b0, intReq}, 32'h0);
    intIn[0] = 1'b0;
    applyStimulus(5'd12, 32'h00000101);
    checkOutput("causeIpClear", causeOut, 32'h0);
    checkOutput("intReqNone", {31'b0, intReq}, 32'h0);
    applyStimulus(5'd13, 32'hFFFFFFFF);
    checkOutput("causeSwOnly", causeOut, 32'h00000300);
    checkOutput("intReqSw", {31'b0, intReq}, 32'h1);
    applyStimulus(5'd13, 32'h0);
    applyStimulus(5'd12, 32'h0);
    checkOutput("statusCleared", statusOut, 32'h10000000);

    // Timer: Compare=20, Count=18 -> match on the wrap that sees Count=20
    applyStimulus(5'd11, 32'd20);
    applyStimulus(5'd9, 32'd18);
    repeat (5) tick();
    checkOutput("timerNotYet", {31'b0, timerInt}, 32'h0);
    tick();
    checkOutput("timerSet", {31'b0, timerInt}, 32'h1);
    checkOutput("causeTi", causeOut, 32'h40000000);
    tick();
    checkOutput("causeTiIp7", causeOut, 32'h40008000);
    checkOutput("timerHeld", {31'b0, timerInt}, 32'h1);

    // Compare write on a match cycle wins
    applyStimulus(5'd11, 32'd30);
    checkOutput("timerClearedByWrite", {31'b0, timerInt}, 32'h0);
    applyStimulus(5'd9, 32'd30);
    tick();
    applyStimulus(5'd11, 32'd30);
    checkOutput("timerWriteWins", {31'b0, timerInt}, 32'h0);
    repeat (4) tick();
    checkOutput("timerStaysClear", {31'b0, timerInt}, 32'h0);
    checkOutput("causeQuiet", causeOut, 32'h0);

    // Exception in a delay slot with a coinciding (discarded) Status write
    excValid    = 1'b1;
    excCode     = 5'h04;
    excPc       = 32'h80000104;
    inDelay     = 1'b1;
    excBadVaddr = 32'h13;
    bus.we      = 1'b1;
    bus.waddr   = 5'd12;
    bus.wdata   = 32'h0000FF03;
    #1;
    checkOutput("excFlush", {31'b0, flush}, 32'h1);
    checkOutput("excAddrEntry", excAddr, 32'hBFC00380);
    tick();
    clearExc();
    readCheck("excEpc", 5'd14, 32'h80000100);
    readCheck("excBadVaddr", 5'd8, 32'h13);
    checkOutput("excStatus", statusOut, 32'h10000002);
    checkOutput("excCause", causeOut, 32'h80000010);

    // Nested exception keeps EPC/BD and BadVAddr
    excValid    = 1'b1;
    excCode     = 5'h0C;
    excPc       = 32'h80000300;
    inDelay     = 1'b0;
    excBadVaddr = 32'h55;
    tick();
    clearExc();
    readCheck("nestedEpc", 5'd14, 32'h80000100);
    readCheck("nestedBadVaddr", 5'd8, 32'h13);
    checkOutput("nestedCause", causeOut, 32'h80000030);

    // ERET with a simultaneous EPC write: forwarded target, write discarded
    eret      = 1'b1;
    bus.we    = 1'b1;
    bus.waddr = 5'd14;
    bus.wdata = 32'h80000200;
    #1;
    checkOutput("eretFwdAddr", excAddr, 32'h80000200);
    checkOutput("eretFlush", {31'b0, flush}, 32'h1);
    checkOutput("eretExlStillSet", statusOut, 32'h10000002);
    tick();
    clearExc();
    checkOutput("eretExlClear", statusOut, 32'h10000000);
    readCheck("eretEpcKept", 5'd14, 32'h80000100);
    checkOutput("idleFlush", {31'b0, flush}, 32'h0);
    eret = 1'b1;
    #1;
    checkOutput("eretAddrEpc", excAddr, 32'h80000100);
    tick();
    clearExc();

    // Address-error exception outside a delay slot
    excValid    = 1'b1;
    excCode     = 5'h05;
    excPc       = 32'h80000400;
    inDelay     = 1'b0;
    excBadVaddr = 32'h77;
    tick();
    clearExc();
    readCheck("adesEpc", 5'd14, 32'h80000400);
    readCheck("adesBadVaddr", 5'd8, 32'h77);
    checkOutput("adesCause", causeOut, 32'h00000014);
    eret = 1'b1;
    tick();
    clearExc();

    // Count wrap after COUNT_DIV cycles
    applyStimulus(5'd9, 32'hFFFFFFFF);
    readCheck("countMax", 5'd9, 32'hFFFFFFFF);
    tick();
    readCheck("countHold", 5'd9, 32'hFFFFFFFF);
    tick();
    readCheck("countWrap", 5'd9, 32'h0);

    // Reset during an exception cycle discards it
    rst         = 1'b1;
    excValid    = 1'b1;
    excCode     = 5'h04;
    excPc       = 32'h80000800;
    excBadVaddr = 32'h99;
    #1;
    checkOutput("rstExcFlush", {31'b0, flush}, 32'h0);
    checkOutput("rstExcAddr2", excAddr, 32'hBFC00000);
    tick();
    rst = 1'b0;
    clearExc();
    checkOutput("rstExcStatus", statusOut, 32'h10000000);
    checkOutput("rstExcCause", causeOut, 32'h0);
    readCheck("rstExcEpc", 5'd14, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
